// File: rtl/sha256_msg_padder_if.sv
// Padded-word stream from the message padder to the compression stage.
// master = padder (drives words), slave = consumer (drives out_ready).
interface sha256_msg_padder_if;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_index;
  logic        out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_index,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: reads a byte-length message from word memory and
// streams the padded message (0x80, zero fill, 64-bit bit length) as 32-bit
// big-endian words, 16 per 512-bit block, over a valid/ready handshake.
module sha256_msg_padder #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [31:0]       message_addr,
  input  logic [31:0]       size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  input  logic [31:0]       mem_read_data,
  output logic              busy,
  output logic              done,
  sha256_msg_padder_if.master st
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_OUT, S_DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_r;
  logic [31:0]       size_r;
  logic [31:0]       last_g;   // index of the final word (total - 1)
  logic [31:0]       g;        // global word counter
  logic [31:0]       g_nxt;
  logic [31:0]       start_last;
  logic [31:0]       data_r;
  logic              valid_r;
  logic [3:0]        index_r;
  logic              last_r;
  logic              unused_addr_hi;

  // Index of the final padded word for a message of sz bytes.
  function automatic logic [31:0] block_last(input logic [31:0] sz);
    logic [31:0] nblk;
    nblk = ((sz + 32'd8) >> 6) + 32'd1;
    return (nblk << 4) - 32'd1;
  endfunction

  // A word needs a memory read when it holds at least one message byte.
  function automatic logic need_mem(input logic [31:0] idx, input logic [31:0] sz);
    return (idx < (sz >> 2)) || ((idx == (sz >> 2)) && (sz[1:0] != 2'd0));
  endfunction

  // Words that carry no message bytes: the lone 0x80 marker word, the two
  // length words, or zero fill. Only called when need_mem() is false, so
  // idx == full here implies the message ended on a word boundary.
  function automatic logic [31:0] gen_word(input logic [31:0] idx,
                                           input logic [31:0] sz,
                                           input logic [31:0] lastg);
    logic [31:0] w;
    w = 32'h0000_0000;
    if (idx == lastg)
      w = sz << 3;
    else if (idx == lastg - 32'd1)
      w = {29'd0, sz[31:29]};
    else if (idx == (sz >> 2))
      w = 32'h8000_0000;
    return w;
  endfunction

  // The partial tail word keeps its leading message bytes, then 0x80, then zeros.
  function automatic logic [31:0] mask_word(input logic [31:0] d,
                                            input logic [31:0] idx,
                                            input logic [31:0] sz);
    logic [31:0] w;
    w = d;
    if (idx == (sz >> 2)) begin
      case (sz[1:0])
        2'd1:    w = {d[31:24], 8'h80, 16'h0000};
        2'd2:    w = {d[31:16], 8'h80, 8'h00};
        2'd3:    w = {d[31:8], 8'h80};
        default: w = d;
      endcase
    end
    return w;
  endfunction

  assign g_nxt      = g + 32'd1;
  assign start_last = block_last(size);

  // Address bits above ADDR_W are ignored by design.
  assign unused_addr_hi = ^message_addr[31:ADDR_W];

  assign mem_we       = 1'b0;
  assign st.out_data  = data_r;
  assign st.out_valid = valid_r;
  assign st.out_index = index_r;
  assign st.out_last  = last_r;

  // Word sequencer: fetch or generate one word at a time, hold it until accepted.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      base_r   <= '0;
      size_r   <= '0;
      last_g   <= '0;
      g        <= '0;
      mem_addr <= '0;
      data_r   <= '0;
      valid_r  <= 1'b0;
      index_r  <= '0;
      last_r   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            base_r  <= message_addr[ADDR_W-1:0];
            size_r  <= size;
            last_g  <= start_last;
            g       <= '0;
            index_r <= '0;
            busy    <= 1'b1;
            if (need_mem(32'd0, size)) begin
              mem_addr <= message_addr[ADDR_W-1:0];
              state    <= S_FETCH;
            end else begin
              // Empty message: word 0 is the 0x80 marker, valid next cycle.
              data_r  <= gen_word(32'd0, size, start_last);
              valid_r <= 1'b1;
              last_r  <= 1'b0;
              state   <= S_OUT;
            end
          end
        end

        S_FETCH: begin
          // Address was presented this cycle; data arrives next cycle.
          mem_addr <= '0;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          data_r  <= mask_word(mem_read_data, g, size_r);
          valid_r <= 1'b1;
          last_r  <= (g == last_g);
          state   <= S_OUT;
        end

        S_OUT: begin
          if (st.out_ready) begin
            if (g == last_g) begin
              valid_r <= 1'b0;
              last_r  <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= S_DONE;
            end else begin
              g       <= g_nxt;
              index_r <= g_nxt[3:0];
              if (need_mem(g_nxt, size_r)) begin
                valid_r  <= 1'b0;
                last_r   <= 1'b0;
                mem_addr <= base_r + g_nxt[ADDR_W-1:0];
                state    <= S_FETCH;
              end else begin
                // Generated words stream back-to-back without leaving OUT.
                data_r <= gen_word(g_nxt, size_r, last_g);
                last_r <= (g_nxt == last_g);
              end
            end
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // A stalled word must stay put until the consumer takes it.
  a_hold: assert property (@(posedge clk) disable iff (!reset_n)
    (valid_r && !st.out_ready) |=> (valid_r && $stable(data_r) &&
                                    $stable(index_r) && $stable(last_r)));

  // The read port is idle except while a fetch is in flight.
  a_addr_idle: assert property (@(posedge clk) disable iff (!reset_n)
    (state != S_FETCH) |-> (mem_addr == '0));

endmodule
